// File: rtl/sensor_gen_pkg.sv
// Shared types, LFSR constants and pixel saturation for the synthetic
// sensor frame source.
package sensor_gen_pkg;

    typedef enum logic [1:0] {
        FLAT    = 2'd0,
        HRAMP   = 2'd1,
        VRAMP   = 2'd2,
        CHECKER = 2'd3
    } pattern_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Clamp a signed value into the unsigned range of a w-bit pixel.
    function automatic logic [31:0] sat_pix(input int v, input int w);
        int hi;
        hi = (1 << w) - 1;
        if (v < 0) begin
            return '0;
        end else if (v > hi) begin
            return 32'(hi);
        end else begin
            return 32'(v);
        end
    endfunction

endpackage

// File: rtl/sensor_frame_gen_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps only when asked,
// so the noise sequence is tied to the valid-pixel stream.
module lfsr16
    import sensor_gen_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        adv_i,
    input  logic [15:0] seed_i,
    output logic [15:0] state_o
);

    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb    = ^(r_state & LFSR_TAPS);
    assign state_o = r_state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= seed_i;
        end else if (adv_i) begin
            r_state <= {r_state[14:0], w_fb};
        end
    end

endmodule

// File: rtl/sensor_frame_gen.sv
// Synthetic sensor frame source: blank, black and image rows with
// registered pixel/sync outputs and LFSR noise on black and flat pixels.
module sensor_frame_gen
    import sensor_gen_pkg::*;
#(
    parameter int PIX_DATA_W       = 12,
    parameter int FRAME_HEIGHT     = 1125,
    parameter int FRAME_WIDTH      = 2200,
    parameter int ACTIVE_WIDTH     = 1920,
    parameter int H_START          = 192,
    parameter int ROW_START_OFFSET = 1,
    parameter int BLACK_HEIGHT     = 10,
    parameter int IMAGE_HEIGHT     = 1080,
    parameter int NOISE_W          = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [1:0]            mode_i,
    input  logic [PIX_DATA_W-1:0] black_level_i,
    input  logic                  noise_en_i,
    output logic                  pix_valid_o,
    output logic [PIX_DATA_W-1:0] pix_data_o,
    output logic                  hd_o,
    output logic                  vd_o,
    output logic                  busy_o,
    output logic [15:0]           frame_cnt_o
);

    localparam int CW        = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int RW        = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int SW        = PIX_DATA_W + 2;
    localparam int BLACK_END = ROW_START_OFFSET + BLACK_HEIGHT;
    localparam int VROW_END  = BLACK_END + IMAGE_HEIGHT;
    localparam int HCOL_END  = H_START + ACTIVE_WIDTH;
    localparam logic signed [SW-1:0] NOISE_OFS = SW'(2 ** (NOISE_W - 1));

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_col;
    logic [RW-1:0]          r_row;
    pattern_mode_t          r_mode;
    logic [PIX_DATA_W-1:0]  r_black;
    logic                   r_noise_en;
    logic                   r_valid;
    logic [PIX_DATA_W-1:0]  r_pix;
    logic                   r_hd;
    logic                   r_vd;
    logic [15:0]            r_frame_cnt;

    logic                   w_run;
    logic                   w_col_last;
    logic                   w_row_last;
    logic                   w_frame_last;
    logic                   w_frame_start;
    logic                   w_row_ok;
    logic                   w_col_ok;
    logic                   w_valid;
    logic                   w_black_row;
    logic [15:0]            w_lfsr;
    logic                   w_unused_lfsr;
    logic [PIX_DATA_W-1:0]  w_x;
    logic [PIX_DATA_W-1:0]  w_y;
    logic signed [SW-1:0]   w_noise;
    logic signed [SW-1:0]   w_sum;
    logic [PIX_DATA_W-1:0]  w_flat;
    logic [PIX_DATA_W-1:0]  w_pix;

    assign w_run         = (r_state == RUN);
    assign w_col_last    = (32'(r_col) == FRAME_WIDTH - 1);
    assign w_row_last    = (32'(r_row) == FRAME_HEIGHT - 1);
    assign w_frame_last  = w_run && w_col_last && w_row_last;
    assign w_frame_start = w_run && (r_row == '0) && (r_col == '0);
    assign w_row_ok      = (32'(r_row) >= ROW_START_OFFSET) && (32'(r_row) < VROW_END);
    assign w_col_ok      = (32'(r_col) >= H_START) && (32'(r_col) < HCOL_END);
    assign w_valid       = w_run && w_row_ok && w_col_ok;
    assign w_black_row   = (32'(r_row) < BLACK_END);

    lfsr16 u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .adv_i   (w_valid),
        .seed_i  (LFSR_SEED),
        .state_o (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:NOISE_W];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (en_i) w_state_nxt = RUN;
            RUN:  if (w_frame_last && !en_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters wrap to 0 on the last cycle, which also leaves them at 0 in IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_col       <= '0;
            r_row       <= '0;
            r_frame_cnt <= '0;
        end else if (w_run) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
            if (w_frame_last) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode     <= FLAT;
            r_black    <= '0;
            r_noise_en <= 1'b0;
        end else if (w_frame_start) begin
            r_mode     <= pattern_mode_t'(mode_i);
            r_black    <= black_level_i;
            r_noise_en <= noise_en_i;
        end
    end

    assign w_x     = PIX_DATA_W'(32'(r_col) - 32'(H_START));
    assign w_y     = PIX_DATA_W'(32'(r_row) - 32'(BLACK_END));
    assign w_noise = r_noise_en ? $signed(SW'(w_lfsr[NOISE_W-1:0])) - NOISE_OFS : '0;
    assign w_sum   = $signed(SW'(r_black)) + w_noise;
    assign w_flat  = PIX_DATA_W'(sat_pix(int'(w_sum), PIX_DATA_W));

    always_comb begin
        w_pix = w_flat;
        if (!w_black_row) begin
            unique case (r_mode)
                FLAT:    w_pix = w_flat;
                HRAMP:   w_pix = w_x;
                VRAMP:   w_pix = w_y;
                CHECKER: w_pix = {PIX_DATA_W{w_x[3] ^ w_y[3]}};
                default: w_pix = w_flat;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_pix   <= '0;
            r_hd    <= 1'b0;
            r_vd    <= 1'b0;
        end else begin
            r_valid <= w_valid;
            r_pix   <= w_valid ? w_pix : '0;
            r_hd    <= w_run && (r_col == '0);
            r_vd    <= w_frame_start;
        end
    end

    assign pix_valid_o = r_valid;
    assign pix_data_o  = r_pix;
    assign hd_o        = r_hd;
    assign vd_o        = r_vd;
    assign busy_o      = w_run;
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_sensor_frame_gen.sv
// Directed bench for sensor_frame_gen on a 16x8 frame: sync counts,
// pixel window, patterns, noise/saturation, early stop and reset.
module tb_sensor_frame_gen;

    localparam int PW  = 12;
    localparam int FW  = 16;
    localparam int FH  = 8;
    localparam int HS  = 2;
    localparam int AW  = 10;
    localparam int RSO = 1;
    localparam int BH  = 2;
    localparam int IH  = 4;
    localparam int NW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [PW-1:0] lvl = '0;
    logic          noise = 1'b0;
    logic          valid;
    logic [PW-1:0] data;
    logic          hd;
    logic          vd;
    logic          busy;
    logic [15:0]   fcnt;

    always #5 clk = ~clk;

    sensor_frame_gen #(
        .PIX_DATA_W       (PW),
        .FRAME_HEIGHT     (FH),
        .FRAME_WIDTH      (FW),
        .ACTIVE_WIDTH     (AW),
        .H_START          (HS),
        .ROW_START_OFFSET (RSO),
        .BLACK_HEIGHT     (BH),
        .IMAGE_HEIGHT     (IH),
        .NOISE_W          (NW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .mode_i        (mode),
        .black_level_i (lvl),
        .noise_en_i    (noise),
        .pix_valid_o   (valid),
        .pix_data_o    (data),
        .hd_o          (hd),
        .vd_o          (vd),
        .busy_o        (busy),
        .frame_cnt_o   (fcnt)
    );

    int n_checks = 0;
    int n_errs   = 0;

    int n_vd     = 0;
    int n_hd     = 0;
    int n_valid  = 0;
    int n_badpos = 0;
    int n_nzinv  = 0;
    int m_row    = 0;
    int m_col    = 0;
    int pix [FH][FW];

    // Receiver-style position tracker: vd clears row, hd advances it.
    always @(negedge clk) begin
        int r;
        int c;
        r = vd ? 0 : (hd ? m_row + 1 : m_row);
        c = hd ? 0 : m_col + 1;
        m_row <= r;
        m_col <= c;
        if (vd) n_vd <= n_vd + 1;
        if (hd) n_hd <= n_hd + 1;
        if (valid) begin
            n_valid <= n_valid + 1;
            if (!(c >= HS && c < HS + AW && r >= RSO && r < RSO + BH + IH))
                n_badpos <= n_badpos + 1;
            if (r >= 0 && r < FH && c >= 0 && c < FW)
                pix[r][c] <= int'(data);
        end else if (data != '0) begin
            n_nzinv <= n_nzinv + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic v, input string tag);
        int i;
        i = 0;
        while (busy !== v && i < 400) begin
            tick();
            i++;
        end
        chk(tag, int'(busy), int'(v));
    endtask

    task automatic wait_row(input int r, input string tag);
        int i;
        i = 0;
        while (m_row != r && i < 400) begin
            tick();
            i++;
        end
        chk(tag, m_row, r);
    endtask

    task automatic run_one_frame();
        en = 1'b1;
        wait_busy(1'b1, "frame_start");
        en = 1'b0;
        wait_busy(1'b0, "frame_end");
        repeat (4) tick();
    endtask

    function automatic int exp_img(input int md, input int bl, input int r, input int c);
        int x;
        int y;
        x = c - HS;
        y = r - RSO - BH;
        if (r < RSO + BH) return bl;
        case (md)
            0: return bl;
            1: return x;
            2: return y;
            default: return (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 4095 : 0;
        endcase
    endfunction

    task automatic img_errs(input int md, input int bl, input int r0, output int errs);
        errs = 0;
        for (int r = r0; r < RSO + BH + IH; r++)
            for (int c = HS; c < HS + AW; c++)
                if (pix[r][c] != exp_img(md, bl, r, c)) errs++;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    function automatic int sat12(input int v);
        if (v < 0) return 0;
        if (v > 4095) return 4095;
        return v;
    endfunction

    task automatic noise_errs(input int bl, inout logic [15:0] s,
                              output int errs, output int clips);
        errs  = 0;
        clips = 0;
        for (int r = RSO; r < RSO + BH + IH; r++) begin
            for (int c = HS; c < HS + AW; c++) begin
                if (pix[r][c] != sat12(bl + int'(s[3:0]) - 8)) errs++;
                if (pix[r][c] == 4095) clips++;
                s = lfsr_next(s);
            end
        end
    endtask

    initial begin
        int b_vd, b_hd, b_val, b_bad, b_nz, fc0, e, k, i;
        logic [15:0] s;

        repeat (3) tick();
        chk("rst_valid", int'(valid), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_hd", int'(hd), 0);
        chk("rst_vd", int'(vd), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fcnt", int'(fcnt), 0);
        rst = 1'b0;
        tick();

        // Three flat frames at level 100, en dropped during the third.
        b_vd = n_vd; b_hd = n_hd; b_val = n_valid; b_bad = n_badpos; b_nz = n_nzinv;
        mode = 2'd0; lvl = 12'd100; noise = 1'b0; en = 1'b1;
        i = 0;
        while (fcnt != 16'd2 && i < 500) begin tick(); i++; end
        chk("flat_fcnt2", int'(fcnt), 2);
        en = 1'b0;
        wait_busy(1'b0, "flat_idle");
        repeat (4) tick();
        chk("flat_vd", n_vd - b_vd, 3);
        chk("flat_hd", n_hd - b_hd, 24);
        chk("flat_valid", n_valid - b_val, 180);
        chk("flat_badpos", n_badpos - b_bad, 0);
        chk("flat_nzinv", n_nzinv - b_nz, 0);
        chk("flat_fcnt3", int'(fcnt), 3);
        img_errs(0, 100, RSO, e);
        chk("flat_data", e, 0);

        mode = 2'd1;
        run_one_frame();
        img_errs(1, 100, RSO, e);
        chk("hramp_errs", e, 0);
        chk("hramp_r4c7", pix[4][7], 5);
        chk("hramp_r4c11", pix[4][11], 9);
        chk("hramp_black", pix[2][5], 100);

        mode = 2'd2;
        run_one_frame();
        img_errs(2, 100, RSO, e);
        chk("vramp_errs", e, 0);
        chk("vramp_r6c3", pix[6][3], 3);
        chk("vramp_r3c9", pix[3][9], 0);

        mode = 2'd3;
        run_one_frame();
        img_errs(3, 100, RSO, e);
        chk("chk_errs", e, 0);
        chk("chk_r3c10", pix[3][10], 4095);
        chk("chk_r3c9", pix[3][9], 0);

        // Stop request at row 2 must not truncate the frame.
        mode = 2'd0;
        fc0 = int'(fcnt);
        b_vd = n_vd; b_hd = n_hd; b_val = n_valid;
        en = 1'b1;
        wait_busy(1'b1, "stop_start");
        wait_row(2, "stop_row2");
        en = 1'b0;
        wait_busy(1'b0, "stop_idle");
        repeat (4) tick();
        chk("stop_hd", n_hd - b_hd, 8);
        chk("stop_vd", n_vd - b_vd, 1);
        chk("stop_valid", n_valid - b_val, 60);
        chk("stop_fcnt", int'(fcnt), fc0 + 1);
        repeat (50) tick();
        chk("stop_quiet_hd", n_hd - b_hd, 8);
        chk("stop_quiet_busy", int'(busy), 0);

        // Reset in the middle of a noisy frame.
        noise = 1'b1; lvl = 12'd3;
        en = 1'b1;
        wait_busy(1'b1, "mrst_start");
        wait_row(4, "mrst_row4");
        repeat (5) tick();
        rst = 1'b1; en = 1'b0;
        tick();
        chk("mrst_valid", int'(valid), 0);
        chk("mrst_data", int'(data), 0);
        chk("mrst_hd", int'(hd), 0);
        chk("mrst_vd", int'(vd), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_fcnt", int'(fcnt), 0);
        rst = 1'b0;
        b_hd = n_hd; b_vd = n_vd; b_val = n_valid;
        repeat (20) tick();
        chk("mrst_quiet_hd", n_hd - b_hd, 0);
        chk("mrst_quiet_vd", n_vd - b_vd, 0);
        chk("mrst_quiet_val", n_valid - b_val, 0);

        // Noise near zero from a freshly seeded LFSR, then near full scale.
        run_one_frame();
        s = 16'hACE1;
        noise_errs(3, s, e, k);
        chk("noise_lo_errs", e, 0);
        chk("noise_lo_r1c2", pix[1][2], 0);
        chk("noise_lo_r1c3", pix[1][3], 0);
        chk("noise_lo_r1c4", pix[1][4], 2);
        lvl = 12'd4094;
        run_one_frame();
        noise_errs(4094, s, e, k);
        chk("noise_hi_errs", e, 0);
        chk("noise_hi_clip", int'(k > 0), 1);
        chk("noise_hi_r1c2", pix[1][2], 4087);

        // Mode change mid-frame only affects the next frame.
        noise = 1'b0; lvl = 12'd100; mode = 2'd0;
        en = 1'b1;
        wait_busy(1'b1, "mchg_start");
        wait_row(3, "mchg_row3");
        mode = 2'd1;
        fc0 = int'(fcnt);
        i = 0;
        while (int'(fcnt) == fc0 && i < 400) begin tick(); i++; end
        chk("mchg_fcnt", int'(fcnt), fc0 + 1);
        en = 1'b0;
        img_errs(0, 100, RSO, e);
        chk("mchg_flat", e, 0);
        wait_busy(1'b0, "mchg_idle");
        repeat (4) tick();
        img_errs(1, 100, RSO, e);
        chk("mchg_ramp", e, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sensor_frame_gen.md
Name: sensor_frame_gen

Overview:
- Synthetic sensor-frame source that drives the same pixel/sync interface the SNR measurer consumes: pix_valid, pix_data, hd, vd.
- Each frame has blank rows, then BLACK_HEIGHT black (dark) rows, then IMAGE_HEIGHT image rows. Black rows carry a programmable level plus LFSR pseudo-noise.
- Used as a bench and bring-up stimulus, so measured SNR can be checked against a known noise amplitude.

Parameters:
- PIX_DATA_W, 12: pixel data width.
- FRAME_HEIGHT, 1125: total rows per frame, including blanking.
- FRAME_WIDTH, 2200: total clocks per row, including blanking.
- ACTIVE_WIDTH, 1920: valid pixels per row. Must satisfy H_START + ACTIVE_WIDTH <= FRAME_WIDTH.
- H_START, 192: column index of the first valid pixel in a row.
- ROW_START_OFFSET, 1: first valid row (first black row).
- BLACK_HEIGHT, 10: number of black rows.
- IMAGE_HEIGHT, 1080: number of image rows after the black rows. ROW_START_OFFSET + BLACK_HEIGHT + IMAGE_HEIGHT <= FRAME_HEIGHT.
- NOISE_W, 4: noise magnitude width. Noise range is [-2^(NOISE_W-1), 2^(NOISE_W-1)-1].

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  run request; sampled only in IDLE and on the last cycle of a frame.
- mode_i  in  2  image-row pattern: 0 flat, 1 horizontal ramp, 2 vertical ramp, 3 checker.
- black_level_i  in  PIX_DATA_W  black/flat level.
- noise_en_i  in  1  add LFSR noise to black and flat pixels.
- pix_valid_o  out  1  pixel qualifier.
- pix_data_o  out  PIX_DATA_W  pixel value.
- hd_o  out  1  one-cycle line strobe.
- vd_o  out  1  one-cycle frame strobe.
- busy_o  out  1  high while in RUN.
- frame_cnt_o  out  16  completed frames; wraps at 2^16.

Behaviour:
- Reset: all outputs 0, state IDLE, row/col counters 0, LFSR = 16'hACE1, frame_cnt_o = 0.
- States:
  - IDLE: counters held at 0, outputs 0. If en_i = 1, go to RUN next cycle; the first RUN cycle is row 0, col 0.
  - RUN: col counts 0..FRAME_WIDTH-1 and wraps; row increments on wrap and counts 0..FRAME_HEIGHT-1.
  - On the last cycle of a frame (row = FRAME_HEIGHT-1, col = FRAME_WIDTH-1): frame_cnt_o increments. If en_i = 1, wrap to row 0 col 0 and stay in RUN; otherwise go to IDLE. Deasserting en_i mid-frame never truncates a frame.
- Config latch: mode_i, black_level_i and noise_en_i are captured at row 0, col 0 of each frame and held constant for that frame.
- Outputs are registered, 1-cycle latency from the counters. hd_o, vd_o, pix_valid_o and pix_data_o for position (r,c) appear together in the same cycle.
- Sync strobes:
  - hd_o = 1 for col = 0 on every row.
  - vd_o = 1 for row = 0, col = 0. Both strobes coincide on that cycle.
  - Consequence: a receiver that clears on vd and increments on hd sees its row count equal to the row index.
- pix_valid_o = 1 when ROW_START_OFFSET <= r < ROW_START_OFFSET + BLACK_HEIGHT + IMAGE_HEIGHT and H_START <= c < H_START + ACTIVE_WIDTH. pix_data_o = 0 when pix_valid_o = 0.
- Noise: n = signed(lfsr[NOISE_W-1:0]) - 2^(NOISE_W-1) if noise_en, else 0.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  - Advances only on cycles where pix_valid_o will be 1.
- Black rows: pix_data = sat(black_level + n), saturated to [0, 2^PIX_DATA_W - 1]. Computed at PIX_DATA_W+2 bits signed.
- Image rows, with x = c - H_START and y = r - ROW_START_OFFSET - BLACK_HEIGHT:
  - mode 0: sat(black_level + n).
  - mode 1: x[PIX_DATA_W-1:0], wraps modulo 2^PIX_DATA_W.
  - mode 2: y[PIX_DATA_W-1:0].
  - mode 3: all-ones if x[3]^y[3], else 0.
  - Noise is not applied in modes 1-3.
- rst_i mid-frame: next cycle is the reset state. No partial strobes or valid pixels follow reset.

Decomposition:
- Package sensor_gen_pkg:
  - pattern_mode_t enum (FLAT, HRAMP, VRAMP, CHECKER).
  - state_t enum (IDLE, RUN).
  - LFSR_SEED = 16'hACE1.
  - LFSR_TAPS = 16'hB400.
  - Saturate function.
- Sub-module lfsr16 (clk_i, rst_i, adv_i, seed, state_o), reused by bench noise checkers.

Test Plan (small parameters: FRAME_WIDTH=16, FRAME_HEIGHT=8, H_START=2, ACTIVE_WIDTH=10, ROW_START_OFFSET=1, BLACK_HEIGHT=2, IMAGE_HEIGHT=4, NOISE_W=4):
- en_i=1 for 3 frames, noise off, black_level=100, mode 0 → per frame: 1 vd_o and 8 hd_o strobes; 60 valid pixels, all 100; valid only at cols 2..11 of rows 1..6; frame_cnt_o reaches 3.
- Mode 1 → image-row data reads 0..9 on each image row. Mode 2 → data equals y (0..3) across rows 3..6.
- noise_en=1, black_level=3 → no value below 0; values equal sat(3 + n) per a reference lfsr16 model. black_level=4094 → clipped at 4095.
- Drop en_i at row 2 → frame completes through row 7 col 15; then IDLE, busy_o=0, no further strobes.
- Assert rst_i at row 4 col 5 → next cycle all outputs 0; LFSR reseeded to ACE1; frame_cnt_o = 0.
- Change mode_i mid-frame 0→1 → current frame remains flat; the following frame is a ramp.
